// File: rtl/pixel_phase_tracker.sv
// Phase tracker for a pixel clock sampled in a fast clock domain running RATIO x faster.
// Optional macro PHASE_SLIP_COUNT_EN enables the realignment counter on slipCount.
module pixel_phase_tracker #(
    parameter int unsigned RATIO          = 6,
    parameter int unsigned PHASE_W        = 3,
    parameter int unsigned ALIGN_PHASE    = 0,
    parameter int unsigned ENABLE_PHASE   = 0,
    parameter int unsigned LOCK_COUNT     = 16,
    parameter int unsigned SLIP_THRESHOLD = 3,
    parameter int unsigned TIMEOUT        = 12
) (
    input  logic               pixelClockXN,
    input  logic               reset,
    input  logic               pixelClockIn,
    output logic [PHASE_W-1:0] pixelClockPhase,
    output logic               pixelEnable,
    output logic               locked,
    output logic               clockMissing,
    output logic [7:0]         slipCount
);

    localparam int unsigned MATCH_W = 8;
    localparam int unsigned MISS_W  = 4;
    localparam int unsigned GAP_W   = 8;

    localparam logic [PHASE_W-1:0] LAST_PHASE  = PHASE_W'(RATIO - 1);
    localparam logic [PHASE_W-1:0] ALIGN_VAL   = PHASE_W'(ALIGN_PHASE);
    localparam logic [PHASE_W-1:0] REALIGN_VAL = PHASE_W'((ALIGN_PHASE + 1) % RATIO);
    localparam logic [PHASE_W-1:0] ENABLE_VAL  = PHASE_W'(ENABLE_PHASE);
    localparam logic [MATCH_W-1:0] LOCK_VAL    = MATCH_W'(LOCK_COUNT);
    localparam logic [MISS_W-1:0]  SLIP_VAL    = MISS_W'(SLIP_THRESHOLD);
    localparam logic [GAP_W-1:0]   GAP_TRIP    = GAP_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0]   GAP_MAX     = '1;
    localparam logic               RST_ENABLE  = (ENABLE_PHASE == 0) ? 1'b1 : 1'b0;

    localparam logic [1:0] ST_ACQUIRE = 2'd0;
    localparam logic [1:0] ST_TRACK   = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    logic               r_sync1;
    logic               r_sync2;
    logic               r_sync3;
    logic [PHASE_W-1:0] r_phase;
    logic               r_enable;
    logic [1:0]         r_state;
    logic [MATCH_W-1:0] r_match_cnt;
    logic [MISS_W-1:0]  r_miss_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic               r_locked;
    logic               r_clock_missing;

    logic               w_edge;
    logic               w_match;
    logic               w_timeout;
    logic               w_realign;
    logic [PHASE_W-1:0] w_phase_next;
    logic [GAP_W-1:0]   w_gap_next;
    logic [1:0]         w_state_next;
    logic [MATCH_W-1:0] w_match_next;
    logic [MISS_W-1:0]  w_miss_next;
    logic               w_missing_next;
    logic [MATCH_W-1:0] w_match_inc;
    logic [MISS_W-1:0]  w_miss_inc;

    // Rising edge of the synchronised pixel clock and its alignment to the phase counter
    assign w_edge      = r_sync2 & ~r_sync3;
    assign w_match     = w_edge && (r_phase == ALIGN_VAL);
    assign w_match_inc = r_match_cnt + MATCH_W'(1);
    assign w_miss_inc  = r_miss_cnt + MISS_W'(1);

    // An edge in the tripping cycle suppresses the timeout
    assign w_timeout   = !w_edge && (r_gap_cnt == GAP_TRIP);
    assign w_gap_next  = w_edge ? '0 :
                         (r_gap_cnt == GAP_MAX) ? r_gap_cnt : r_gap_cnt + GAP_W'(1);

    assign w_phase_next = w_realign ? REALIGN_VAL :
                          (r_phase == LAST_PHASE) ? '0 : r_phase + PHASE_W'(1);

    // Next-state and counter logic
    always_comb begin
        w_state_next   = r_state;
        w_match_next   = r_match_cnt;
        w_miss_next    = r_miss_cnt;
        w_missing_next = r_clock_missing;
        w_realign      = 1'b0;

        if (w_edge) begin
            w_missing_next = 1'b0;
        end

        if (w_timeout) begin
            w_state_next   = ST_ACQUIRE;
            w_match_next   = '0;
            w_miss_next    = '0;
            w_missing_next = 1'b1;
        end else begin
            case (r_state)
                ST_ACQUIRE: begin
                    if (w_edge) begin
                        w_realign    = 1'b1;
                        w_match_next = '0;
                        w_state_next = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (w_match) begin
                        w_match_next = w_match_inc;
                        if (w_match_inc == LOCK_VAL) begin
                            w_state_next = ST_LOCKED;
                        end
                    end else if (w_edge) begin
                        w_realign    = 1'b1;
                        w_match_next = '0;
                    end
                end
                ST_LOCKED: begin
                    if (w_match) begin
                        w_miss_next = '0;
                    end else if (w_edge) begin
                        w_miss_next = w_miss_inc;
                        if (w_miss_inc == SLIP_VAL) begin
                            w_realign    = 1'b1;
                            w_miss_next  = '0;
                            w_match_next = '0;
                            w_state_next = ST_TRACK;
                        end
                    end
                end
                default: begin
                    w_state_next = ST_ACQUIRE;
                    w_match_next = '0;
                    w_miss_next  = '0;
                end
            endcase
        end
    end

    // State, synchroniser and output registers
    always_ff @(posedge pixelClockXN) begin
        if (reset) begin
            r_sync1         <= 1'b0;
            r_sync2         <= 1'b0;
            r_sync3         <= 1'b0;
            r_phase         <= '0;
            r_enable        <= RST_ENABLE;
            r_state         <= ST_ACQUIRE;
            r_match_cnt     <= '0;
            r_miss_cnt      <= '0;
            r_gap_cnt       <= '0;
            r_locked        <= 1'b0;
            r_clock_missing <= 1'b0;
        end else begin
            r_sync1         <= pixelClockIn;
            r_sync2         <= r_sync1;
            r_sync3         <= r_sync2;
            r_phase         <= w_phase_next;
            r_enable        <= (w_phase_next == ENABLE_VAL);
            r_state         <= w_state_next;
            r_match_cnt     <= w_match_next;
            r_miss_cnt      <= w_miss_next;
            r_gap_cnt       <= w_gap_next;
            r_locked        <= (w_state_next == ST_LOCKED);
            r_clock_missing <= w_missing_next;
        end
    end

`ifdef PHASE_SLIP_COUNT_EN
    logic       w_slip_event;
    logic [7:0] r_slip_cnt;

    // Only a threshold-triggered realignment out of LOCKED counts as a slip
    assign w_slip_event = (r_state == ST_LOCKED) && w_edge && !w_match && (w_miss_inc == SLIP_VAL);

    always_ff @(posedge pixelClockXN) begin
        if (reset) begin
            r_slip_cnt <= '0;
        end else if (w_slip_event && (r_slip_cnt != 8'hFF)) begin
            r_slip_cnt <= r_slip_cnt + 8'd1;
        end
    end

    assign slipCount = r_slip_cnt;
`else
    assign slipCount = 8'd0;
`endif

    assign pixelClockPhase = r_phase;
    assign pixelEnable     = r_enable;
    assign locked          = r_locked;
    assign clockMissing    = r_clock_missing;

endmodule

// File: tb/tb_pixel_phase_tracker.sv
// Bench for pixel_phase_tracker: directed scenarios plus random pixel-clock runs,
// checked every cycle against a behavioural model of the tracking rules.
module tb_pixel_phase_tracker;

    localparam int RATIO   = 6;
    localparam int ALIGN   = 0;
    localparam int ENP     = 0;
    localparam int LOCKN   = 16;
    localparam int SLIPN   = 3;
    localparam int TMO     = 12;
`ifdef PHASE_SLIP_COUNT_EN
    localparam int SLIP_ON = 1;
`else
    localparam int SLIP_ON = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       pin;
    logic [2:0] phase;
    logic       enable;
    logic       locked;
    logic       missing;
    logic [7:0] slips;

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode 0 = acquire, 1 = track, 2 = locked
    bit hist[$];
    int m_phase, m_mode, m_aligned, m_misses, m_since, m_slips;
    bit m_locked, m_missing;

    always #5 clk = ~clk;

    pixel_phase_tracker dut (
        .pixelClockXN   (clk),
        .reset          (reset),
        .pixelClockIn   (pin),
        .pixelClockPhase(phase),
        .pixelEnable    (enable),
        .locked         (locked),
        .clockMissing   (missing),
        .slipCount      (slips)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit p, input bit r);
        bit edge_seen, on_grid, realign;
        if (r) begin
            hist = {1'b0, 1'b0, 1'b0};
            m_phase = 0; m_mode = 0; m_aligned = 0; m_misses = 0;
            m_since = 0; m_slips = 0; m_locked = 0; m_missing = 0;
            return;
        end
        edge_seen = hist[1] && !hist[2];
        hist.push_front(p);
        void'(hist.pop_back());
        on_grid = edge_seen && (m_phase == ALIGN);
        realign = 0;
        m_since = edge_seen ? 0 : ((m_since < 1000) ? m_since + 1 : m_since);
        if (!edge_seen && m_since == TMO) begin
            m_mode = 0; m_aligned = 0; m_misses = 0; m_missing = 1;
        end else begin
            if (edge_seen) m_missing = 0;
            if (m_mode == 0) begin
                if (edge_seen) begin realign = 1; m_aligned = 0; m_mode = 1; end
            end else if (m_mode == 1) begin
                if (on_grid) begin
                    m_aligned++;
                    if (m_aligned == LOCKN) m_mode = 2;
                end else if (edge_seen) begin
                    realign = 1; m_aligned = 0;
                end
            end else begin
                if (on_grid) m_misses = 0;
                else if (edge_seen) begin
                    m_misses++;
                    if (m_misses == SLIPN) begin
                        realign = 1; m_misses = 0; m_aligned = 0; m_mode = 1;
                        if (SLIP_ON != 0 && m_slips < 255) m_slips++;
                    end
                end
            end
        end
        m_phase  = realign ? (ALIGN + 1) % RATIO : (m_phase + 1) % RATIO;
        m_locked = (m_mode == 2);
    endtask

    task automatic tick(input bit p, input bit r);
        @(negedge clk);
        pin = p;
        reset = r;
        @(posedge clk);
        model_step(p, r);
        #1;
        check("phase",   32'(phase),   32'(m_phase));
        check("enable",  32'(enable),  32'(m_phase == ENP));
        check("locked",  32'(locked),  32'(m_locked));
        check("missing", 32'(missing), 32'(m_missing));
        check("slips",   32'(slips),   32'(m_slips));
    endtask

    task automatic pix(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            repeat (hi) tick(1'b1, 1'b0);
            repeat (lo) tick(1'b0, 1'b0);
        end
    endtask

    initial begin
        bit cur;
        int run;
        pin = 1'b0;
        reset = 1'b1;
        hist = {1'b0, 1'b0, 1'b0};

        // Reset state
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        check("rst_phase",   32'(phase),   32'd0);
        check("rst_enable",  32'(enable),  32'd1);
        check("rst_locked",  32'(locked),  32'd0);
        check("rst_missing", 32'(missing), 32'd0);
        check("rst_slips",   32'(slips),   32'd0);

        // Random start offset, then a clean 3/3 pixel clock until lock
        repeat ($urandom_range(0, 5)) tick(1'b0, 1'b0);
        pix(30, 3, 3);
        check("lock1_locked",  32'(locked),  32'd1);
        check("lock1_missing", 32'(missing), 32'd0);
        check("lock1_slips",   32'(slips),   32'd0);

        // Permanent 2-cycle shift: slip, realign, relock
        repeat (2) tick(1'b0, 1'b0);
        pix(30, 3, 3);
        check("slip1_locked", 32'(locked), 32'd1);
        check("slip1_slips",  32'(slips),  32'(SLIP_ON));

        // One early edge, then back on the original grid: no slip
        pix(1, 2, 2);
        pix(1, 3, 5);
        pix(10, 3, 3);
        check("glitch_locked", 32'(locked), 32'd1);
        check("glitch_slips",  32'(slips),  32'(SLIP_ON));

        // Clock held low: timeout
        repeat (20) tick(1'b0, 1'b0);
        check("tmo_missing", 32'(missing), 32'd1);
        check("tmo_locked",  32'(locked),  32'd0);

        // Restart and relock
        pix(30, 3, 3);
        check("restart_missing", 32'(missing), 32'd0);
        check("restart_locked",  32'(locked),  32'd1);

        // Second shift to reach two slips, then reset while locked
        repeat (2) tick(1'b0, 1'b0);
        pix(30, 3, 3);
        check("slip2_locked", 32'(locked), 32'd1);
        check("slip2_slips",  32'(slips),  32'(2 * SLIP_ON));
        tick(1'b1, 1'b1);
        check("rst2_phase",  32'(phase),  32'd0);
        check("rst2_locked", 32'(locked), 32'd0);
        check("rst2_slips",  32'(slips),  32'd0);

        // Random high/low runs including gaps long enough to time out
        cur = 1'b0;
        for (int k = 0; k < 80; k++) begin
            run = $urandom_range(1, 8);
            repeat (run) tick(cur, 1'b0);
            cur = !cur;
            if (k == 40) tick(cur, 1'b1);
        end
        pix(30, 3, 3);
        check("final_locked", 32'(locked), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
